// File: rtl/seq_tx_pkg.sv
// Shared types and constants for the serial sequence path.
// Both transmitter and detector agree on DEFAULT_PAT.
package seq_tx_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        GAP,
        DONE
    } tx_state_t;

    localparam logic [3:0] DEFAULT_PAT = 4'b1011;

endpackage

// File: rtl/sequence_pattern_tx.sv
// Serial pattern transmitter: shifts a latched pattern out MSB first,
// repeating it a programmable number of frames with idle gaps.
module sequence_pattern_tx
    import seq_tx_pkg::*;
#(
    parameter int               PAT_W       = 4,
    parameter logic [PAT_W-1:0] DEFAULT_PAT = seq_tx_pkg::DEFAULT_PAT,
    parameter int               CNT_W       = 8,
    parameter int               GAP_W       = 4,
    parameter int               FCNT_W      = 16
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic              start,
    input  logic              use_default,
    input  logic [PAT_W-1:0]  pattern,
    input  logic [CNT_W-1:0]  repeat_cnt,
    input  logic [GAP_W-1:0]  gap,
    input  logic              abort,
    output logic              serial_out,
    output logic              bit_valid,
    output logic              busy,
    output logic              done,
    output logic [FCNT_W-1:0] frames_sent
);

    localparam int IDX_W = $clog2(PAT_W);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PAT_W - 1);

    tx_state_t          state, state_n;
    logic [PAT_W-1:0]   pat_q, pat_n;
    logic [PAT_W-1:0]   shreg, shreg_n;
    logic [IDX_W-1:0]   bit_idx, bit_idx_n;
    logic [CNT_W-1:0]   left_q, left_n;
    logic [GAP_W-1:0]   gap_q, gap_n;
    logic [GAP_W-1:0]   gap_cnt, gap_cnt_n;
    logic               serial_n, valid_n, busy_n, done_n;
    logic [FCNT_W-1:0]  frames_n;
    logic [PAT_W-1:0]   pat_sel;

    always_ff @(posedge clk_sys or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            pat_q       <= '0;
            shreg       <= '0;
            bit_idx     <= '0;
            left_q      <= '0;
            gap_q       <= '0;
            gap_cnt     <= '0;
            serial_out  <= 1'b0;
            bit_valid   <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            frames_sent <= '0;
        end else begin
            state       <= state_n;
            pat_q       <= pat_n;
            shreg       <= shreg_n;
            bit_idx     <= bit_idx_n;
            left_q      <= left_n;
            gap_q       <= gap_n;
            gap_cnt     <= gap_cnt_n;
            serial_out  <= serial_n;
            bit_valid   <= valid_n;
            busy        <= busy_n;
            done        <= done_n;
            frames_sent <= frames_n;
        end
    end

    always_comb begin
        state_n   = state;
        pat_n     = pat_q;
        shreg_n   = shreg;
        bit_idx_n = bit_idx;
        left_n    = left_q;
        gap_n     = gap_q;
        gap_cnt_n = gap_cnt;
        serial_n  = 1'b0;
        valid_n   = 1'b0;
        busy_n    = 1'b0;
        done_n    = 1'b0;
        frames_n  = frames_sent;
        pat_sel   = use_default ? DEFAULT_PAT : pattern;

        unique case (state)
            IDLE: begin
                if (start && !abort) begin
                    pat_n     = pat_sel;
                    shreg_n   = pat_sel << 1;
                    serial_n  = pat_sel[PAT_W-1];
                    valid_n   = 1'b1;
                    busy_n    = 1'b1;
                    bit_idx_n = '0;
                    // left_q counts frames remaining after the current one
                    left_n    = (repeat_cnt == '0) ? '0 : repeat_cnt - 1'b1;
                    gap_n     = gap;
                    state_n   = SHIFT;
                end
            end
            SHIFT: begin
                busy_n = 1'b1;
                if (bit_idx == LAST_IDX) begin
                    if (frames_sent != '1) begin
                        frames_n = frames_sent + 1'b1;
                    end
                    if (left_q != '0) begin
                        left_n = left_q - 1'b1;
                        if (gap_q == '0) begin
                            serial_n  = pat_q[PAT_W-1];
                            valid_n   = 1'b1;
                            shreg_n   = pat_q << 1;
                            bit_idx_n = '0;
                        end else begin
                            gap_cnt_n = gap_q - 1'b1;
                            state_n   = GAP;
                        end
                    end else begin
                        done_n  = 1'b1;
                        state_n = DONE;
                    end
                end else begin
                    serial_n  = shreg[PAT_W-1];
                    valid_n   = 1'b1;
                    shreg_n   = shreg << 1;
                    bit_idx_n = bit_idx + 1'b1;
                end
            end
            GAP: begin
                busy_n = 1'b1;
                if (gap_cnt == '0) begin
                    serial_n  = pat_q[PAT_W-1];
                    valid_n   = 1'b1;
                    shreg_n   = pat_q << 1;
                    bit_idx_n = '0;
                    state_n   = SHIFT;
                end else begin
                    gap_cnt_n = gap_cnt - 1'b1;
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        // Cancel wins over everything; the interrupted frame is not counted.
        if (abort && state != IDLE) begin
            state_n  = IDLE;
            serial_n = 1'b0;
            valid_n  = 1'b0;
            busy_n   = 1'b0;
            done_n   = 1'b0;
            frames_n = frames_sent;
        end
    end

endmodule
